// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller:
// active-low hex glyph table, blank pattern and index-width helper.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Never returns 0 so single-digit builds still get a 1-bit index.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble plus decimal point to active-low segment pattern.
// Bit 7 is the DP, bits 6:0 are segments g..a.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_hex,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  logic [7:0] w_pat;

  assign w_pat = HEX_SEG[i_hex];
  assign o_seg = {w_pat[7] & ~i_dp, w_pat[6:0]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-aligned double
// buffering, per-digit DP/blank and PWM brightness.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BRIGHT_W   = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done,
  output logic                  applied
);

  localparam int IW = clog2(DIGITS);
  localparam int CW = clog2(SCAN_DIV);
  localparam int L  = SCAN_DIV >> BRIGHT_W;

  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  localparam logic [7:0] OUT_SEG_OFF =
    (ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
  localparam logic [DIGITS-1:0] OUT_SEL_OFF =
    (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [BRIGHT_W-1:0]   r_bright;
  logic [4*DIGITS-1:0]   r_st_data;
  logic [DIGITS-1:0]     r_st_dp;
  logic [DIGITS-1:0]     r_st_blank;
  logic [4*DIGITS-1:0]   r_sh_data;
  logic [DIGITS-1:0]     r_sh_dp;
  logic [DIGITS-1:0]     r_sh_blank;
  logic                  r_pend;
  logic                  r_fd;
  logic                  r_app;
  logic [7:0]            r_seg;
  logic [DIGITS-1:0]     r_sel;

  logic                  w_slot_end;
  logic                  w_bnd;
  logic                  w_commit;
  logic [3:0]            w_nib;
  logic [7:0]            w_dec;
  logic [31:0]           w_thr;
  logic                  w_lit;
  logic                  w_on;
  logic [DIGITS-1:0]     w_hot;
  logic [7:0]            w_seg_al;
  logic [DIGITS-1:0]     w_sel_al;

  assign w_slot_end = (r_cnt == CNT_MAX);
  assign w_bnd      = enable & w_slot_end & (r_idx == IDX_MAX);
  // While disabled every cycle acts as a frame boundary.
  assign w_commit   = w_bnd | ~enable;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_fd  <= 1'b0;
    end else if (!enable) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_fd  <= 1'b0;
    end else begin
      r_fd <= w_bnd;
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_st_data  <= '0;
      r_st_dp    <= '0;
      r_st_blank <= '0;
      r_sh_data  <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '1;
      r_pend     <= 1'b0;
      r_app      <= 1'b0;
    end else begin
      r_app <= 1'b0;
      if (load && w_commit) begin
        r_sh_data  <= data;
        r_sh_dp    <= dp;
        r_sh_blank <= blank;
        r_pend     <= 1'b0;
        r_app      <= 1'b1;
      end else if (load) begin
        r_st_data  <= data;
        r_st_dp    <= dp;
        r_st_blank <= blank;
        r_pend     <= 1'b1;
      end else if (w_commit && r_pend) begin
        r_sh_data  <= r_st_data;
        r_sh_dp    <= r_st_dp;
        r_sh_blank <= r_st_blank;
        r_pend     <= 1'b0;
        r_app      <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bright <= '0;
    end else if (r_cnt == '0) begin
      r_bright <= bright;
    end
  end

  assign w_nib = r_sh_data[{r_idx, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .i_hex (w_nib),
    .i_dp  (r_sh_dp[r_idx]),
    .o_seg (w_dec)
  );

  // Slot start is always lit since the threshold is at least L >= 1.
  assign w_thr = (32'(r_bright) + 32'd1) * 32'(L);
  assign w_lit = (32'(r_cnt) < w_thr);
  assign w_on  = enable & ~r_sh_blank[r_idx] & w_lit;
  assign w_hot = DIGITS'(1) << r_idx;

  assign w_seg_al = w_on ? w_dec  : SEG_OFF;
  assign w_sel_al = w_on ? ~w_hot : '1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_seg <= OUT_SEG_OFF;
      r_sel <= OUT_SEL_OFF;
    end else if (ACTIVE_LOW != 0) begin
      r_seg <= w_seg_al;
      r_sel <= w_sel_al;
    end else begin
      r_seg <= ~w_seg_al;
      r_sel <= ~w_sel_al;
    end
  end

  assign seg        = r_seg;
  assign sel        = r_sel;
  assign frame_done = r_fd;
  assign applied    = r_app;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position reference
// model queues per-cycle expectations, a monitor pops and compares.
module tb_seg_scan_ctrl;

  localparam int D  = 4;
  localparam int SD = 8;
  localparam int BW = 2;
  localparam int FR = D * SD;
  localparam int LL = SD >> BW;

  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   data = '0;
  logic [3:0]    dp = '0;
  logic [3:0]    blank = '0;
  logic [BW-1:0] bright = '0;

  logic [7:0] seg, seg_n;
  logic [3:0] sel, sel_n;
  logic       fd, fd_n, ap, ap_n;

  seg_scan_ctrl #(
    .DIGITS(D), .SCAN_DIV(SD),
    .BRIGHT_W(BW), .ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK), .RST(RST), .enable(enable),
    .load(load), .data(data), .dp(dp),
    .blank(blank), .bright(bright),
    .seg(seg), .sel(sel),
    .frame_done(fd), .applied(ap)
  );

  seg_scan_ctrl #(
    .DIGITS(D), .SCAN_DIV(SD),
    .BRIGHT_W(BW), .ACTIVE_LOW(0)
  ) dut_n (
    .CLK(CLK), .RST(RST), .enable(enable),
    .load(load), .data(data), .dp(dp),
    .blank(blank), .bright(bright),
    .seg(seg_n), .sel(sel_n),
    .frame_done(fd_n), .applied(ap_n)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] seg;
    logic [3:0] sel;
    logic       fd;
    logic       ap;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int n_cyc = 0;
  int n_app = 0;
  int n_fd = 0;

  // Reference model: frame position, buffers as digit arrays.
  int         m_pos;
  int         m_bs;
  bit         m_pend;
  logic [3:0] m_sh_d [D];
  bit         m_sh_dp [D];
  bit         m_sh_bl [D];
  logic [3:0] m_st_d [D];
  bit         m_st_dp [D];
  bit         m_st_bl [D];

  task automatic model_reset();
    m_pos  = 0;
    m_bs   = 0;
    m_pend = 0;
    for (int i = 0; i < D; i++) begin
      m_sh_d[i]  = '0;
      m_sh_dp[i] = 0;
      m_sh_bl[i] = 1;
      m_st_d[i]  = '0;
      m_st_dp[i] = 0;
      m_st_bl[i] = 0;
    end
  endtask

  task automatic model_push();
    exp_t e;
    int   dg, sl;
    bit   bnd;
    e.seg = 8'hFF;
    e.sel = 4'hF;
    e.fd  = 1'b0;
    e.ap  = 1'b0;
    if (RST) begin
      model_reset();
    end else begin
      dg = m_pos / SD;
      sl = m_pos % SD;
      if (enable && sl == 0) m_bs = int'(bright);
      if (enable && !m_sh_bl[dg] && sl < (m_bs + 1) * LL) begin
        e.seg = GLYPH[m_sh_d[dg]];
        if (m_sh_dp[dg]) e.seg[7] = 1'b0;
        e.sel = 4'hF;
        e.sel[dg] = 1'b0;
      end
      bnd  = !enable || (m_pos == FR - 1);
      e.fd = enable && (m_pos == FR - 1);
      if (load) begin
        for (int i = 0; i < D; i++) begin
          m_st_d[i]  = data[i*4 +: 4];
          m_st_dp[i] = dp[i];
          m_st_bl[i] = blank[i];
        end
        m_pend = 1;
      end
      if (bnd && m_pend) begin
        m_sh_d  = m_st_d;
        m_sh_dp = m_st_dp;
        m_sh_bl = m_st_bl;
        m_pend  = 0;
        e.ap    = 1'b1;
      end
      m_pos = enable ? (m_pos + 1) % FR : 0;
    end
    exp_q.push_back(e);
  endtask

  task automatic check(input string nm, input logic [13:0] act,
                       input logic [13:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", nm, n_cyc, act, req);
  endtask

  task automatic check_int(input string nm, input int act,
                           input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s got=%0d want=%0d", nm, act, req);
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    n_cyc++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("out", {seg, sel, fd, ap},
            {e.seg, e.sel, e.fd, e.ap});
      check("out_hi", {seg_n, sel_n, fd_n, ap_n},
            {~e.seg, ~e.sel, e.fd, e.ap});
      if (ap === 1'b1) n_app++;
      if (fd === 1'b1) n_fd++;
    end
  end

  task automatic tick();
    model_push();
    @(posedge CLK);
    #3;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_bnd();
    int k;
    k = 0;
    while (m_pos != FR - 1 && k < 4 * FR) begin
      tick();
      k++;
    end
    if (k >= 4 * FR) check_int("bnd_timeout", k, 0);
  endtask

  int a0, f0;

  initial begin
    model_reset();
    RST = 1'b1;
    run(3);
    RST = 1'b0;

    enable = 1'b1;
    f0 = n_fd;
    run(64);
    check_int("fd_count", n_fd - f0, 2);

    bright = 2'd3;
    data = 16'h3210; dp = 4'b0100; blank = 4'b0000;
    load = 1'b1; tick(); load = 1'b0;
    run(80);

    wait_bnd(); tick();
    data = 16'h1111; load = 1'b1; tick(); load = 1'b0;
    a0 = n_app;
    run(5);
    data = 16'h2222; load = 1'b1; tick(); load = 1'b0;
    data = 16'h1111;
    run(40);
    check_int("apply_once", n_app - a0, 1);

    bright = 2'd0; run(40);
    bright = 2'd1; run(40);
    bright = 2'd3;

    wait_bnd();
    data = 16'hABCD; dp = 4'b1001; load = 1'b1;
    a0 = n_app;
    tick(); load = 1'b0;
    run(2);
    check_int("bnd_apply", n_app - a0, 1);
    run(32);

    run(3);
    data = 16'h5555; dp = 4'b0000;
    load = 1'b1; tick(); load = 1'b0;
    run(2);
    RST = 1'b1; tick(); RST = 1'b0;
    a0 = n_app;
    run(40);
    check_int("rst_no_apply", n_app - a0, 0);

    data = 16'h0008; dp = 4'b0000; blank = 4'b1110;
    load = 1'b1; tick(); load = 1'b0;
    run(40);

    run(5);
    data = 16'hF0E1; blank = 4'b0000;
    load = 1'b1; tick(); load = 1'b0;
    run(2);
    enable = 1'b0; run(5);
    enable = 1'b1; run(40);

    for (int i = 0; i < 600; i++) begin
      load   = ($urandom_range(0, 11) == 0);
      data   = 16'($urandom);
      dp     = 4'($urandom);
      blank  = 4'($urandom & $urandom);
      if ($urandom_range(0, 19) == 0) bright = 2'($urandom);
      enable = ($urandom_range(0, 39) != 0);
      tick();
    end
    load = 1'b0;
    enable = 1'b1;
    run(4);

    check_int("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed seven-segment scan controller that drives a common-segment display of DIGITS digits. It displays a host-supplied hex value per digit with a per-digit decimal point and per-digit blanking, plus global PWM brightness. Updates are double-buffered and applied only at frame boundaries, so a frame never mixes old and new data. It sits between application logic and the board's seg/sel pins, replacing the fixed 8-digit demo scanner.

## Interface
Parameters:
- DIGITS, 8: number of digits, range 1..8; sets the width of sel, dp and blank, and data is 4*DIGITS bits.
- SCAN_DIV, 50000: clock cycles per digit slot; must be ≥ 2^BRIGHT_W and a multiple of it.
- BRIGHT_W, 3: width of the brightness input.
- ACTIVE_LOW, 1: 1 means seg and sel are active-low; 0 inverts both.

Ports:
- CLK, input, 1: system clock.
- RST, input, 1: synchronous, active-high reset.
- enable, input, 1: scanning enabled.
- load, input, 1: single-cycle strobe that captures data, dp and blank.
- data, input, 4*DIGITS: hex nibbles, digit 0 in bits [3:0].
- dp, input, DIGITS: decimal point on, 1 per digit.
- blank, input, DIGITS: digit forced dark, 1 per digit.
- bright, input, BRIGHT_W: on-time level; 0 is the dimmest and all-ones is fully on.
- seg, output, 8: segments; bit 7 is the DP, bits 6:0 are g..a.
- sel, output, DIGITS: digit enables; only one is active at a time.
- frame_done, output, 1: 1-cycle pulse at the end of every frame.
- applied, output, 1: 1-cycle pulse when pending data enters the shadow registers.

## Operation
- Reset: seg and sel are all inactive (8'hFF and all ones when ACTIVE_LOW=1). cnt=0, idx=0, shadow data=0, shadow dp=0, shadow blank=all ones, pending=0, frame_done=0, applied=0.
- Slot counter cnt runs 0..SCAN_DIV-1. On cnt==SCAN_DIV-1, cnt goes to 0 and idx advances. idx wraps from DIGITS-1 to 0.
- Frame boundary: cnt==SCAN_DIV-1 and idx==DIGITS-1. frame_done pulses in the following cycle.
- Staging: load=1 captures data, dp and blank into staging and sets pending. Repeated loads before a boundary overwrite staging; the last load wins.
- At a boundary with pending=1: shadow is loaded from staging, pending clears, and applied pulses in the next cycle.
- Load coinciding with a boundary: the inputs go straight to shadow, pending stays 0, and applied pulses.
- enable=0: seg and sel are inactive, cnt and idx are held at 0, and frame_done is not produced. Any pending load is applied on the next cycle, as if at a boundary. When enable rises, scanning restarts at digit 0, slot cycle 0.
- Brightness: L = SCAN_DIV >> BRIGHT_W. bright is sampled at cnt==0. The digit is lit while cnt < (bright_s+1)*L and dark for the rest of the slot.
- Decode, active-low form for hex 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  - dp=1 clears bit 7.
  - A blanked digit, or the dark PWM phase, gives all segments off and sel inactive.
  - ACTIVE_LOW=0 bitwise-inverts both seg and sel.

## Timing
- seg and sel are registered. They reflect the idx and cnt values of the previous cycle, so there is a 1-cycle latency.
- Load-to-display latency is at most DIGITS*SCAN_DIV+2 cycles.
- Frame period is DIGITS*SCAN_DIV cycles.
- RST mid-frame: all state returns to reset values on the next edge, and staging is discarded.
- bright changes mid-slot take effect at the next slot start.
- data, dp and blank are sampled only on load; they may change freely at other times.

## Structure
- Package seg_pkg:
  - the 16-entry hex-to-segment constant array (active-low);
  - SEG_OFF = 8'hFF;
  - a digit-index width function clog2(DIGITS).
- Sub-module seg_hex_decode: combinational nibble + dp → 8-bit active-low pattern.
- Top-level contents: slot counter, index counter, staging/shadow/pending logic, PWM compare, polarity and output registers.

## Test plan
Unless stated otherwise, DIGITS=4, SCAN_DIV=8, BRIGHT_W=2, ACTIVE_LOW=1.
- Reset, then enable=1 with no load:
  - sel stays 4'hF and seg stays 8'hFF for 64 cycles (all blanked);
  - frame_done pulses every 32 cycles.
- Load data=16'h3210, dp=4'b0100, blank=0, bright=3:
  - after the boundary, applied pulses;
  - frame sequence is sel=E/seg=C0, D/F9, B/24, 7/B0, each held 8 cycles.
- Loads of 16'h1111 and then 16'h2222 in the same frame:
  - only 16'h2222 is displayed;
  - applied pulses exactly once;
  - no frame shows 1s.
- bright=0:
  - each slot is lit for 2 cycles then dark for 6;
  - with bright=1, lit for 4 cycles.
- Load on the boundary cycle: shadow updates immediately, pending stays 0, and applied pulses once.
- RST asserted mid-slot with pending set:
  - outputs are off in the next cycle;
  - after release, the display stays blank and no applied pulse occurs.
- ACTIVE_LOW=0 with digit 8: seg=8'h7F and sel=4'b0001 for digit 0.
